// File: rtl/karatsuba_seq_ctrl.sv
// Sequential Karatsuba multiplier controller: an m x m product built from three
// issues to one external m/2 x m/2 pipelined multiplier (Z0, Z2, middle term).
// Ports: X/Y operand streams and Z product stream (AXI-Stream valid/ready),
//   mul_a/mul_b/mul_p external multiplier link, busy = not idle.
//   clk with synchronous active-high rst.
module karatsuba_seq_ctrl #(
    parameter int m   = 328,
    parameter int LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             X_tvalid,
    output logic             X_tready,
    input  logic [m-1:0]     X_tdata,
    input  logic             Y_tvalid,
    output logic             Y_tready,
    input  logic [m-1:0]     Y_tdata,
    output logic             Z_tvalid,
    input  logic             Z_tready,
    output logic [2*m-1:0]   Z_tdata,
    output logic [m/2-1:0]   mul_a,
    output logic [m/2-1:0]   mul_b,
    input  logic [m-1:0]     mul_p,
    output logic             busy
);
    localparam int m2 = m / 2;
    localparam int CW = $clog2(LAT + 4);

    if ((m % 2) != 0) begin : g_m_odd
        $error("karatsuba_seq_ctrl: m must be even");
    end
    if (LAT < 1) begin : g_lat_bad
        $error("karatsuba_seq_ctrl: LAT must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_DRAIN, S_COMBINE, S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [m2-1:0]   x1_q, x1_d, y1_q, y1_d;
    logic [m2-1:0]   dxm_q, dxm_d, dym_q, dym_d;
    logic            sx_q, sx_d, sy_q, sy_d;
    logic [m2-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [m-1:0]    z0_q, z0_d, z2_q, z2_d, xy_q, xy_d;
    logic [2*m-1:0]  z_q, z_d;
    logic            accept;
    logic            cap_en;
    logic [m2:0]     dx, dy;
    logic [m:0]      z1;

    // State register and all datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            dxm_q   <= '0;
            dym_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            z0_q    <= '0;
            z2_q    <= '0;
            xy_q    <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            dxm_q   <= dxm_d;
            dym_q   <= dym_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            z0_q    <= z0_d;
            z2_q    <= z2_d;
            xy_q    <= xy_d;
            z_q     <= z_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (accept) state_d = S_ISSUE;
            S_ISSUE:   if (cnt_q == CW'(2)) state_d = S_DRAIN;
            // Middle product lands at the edge leaving cnt == LAT+2
            S_DRAIN:   if (cnt_q == CW'(LAT + 2)) state_d = S_COMBINE;
            S_COMBINE: state_d = S_OUT;
            S_OUT:     if (Z_tready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        X_tready = (state_q == S_IDLE) && !rst;
        Y_tready = (state_q == S_IDLE) && !rst;
        Z_tvalid = (state_q == S_OUT);
        busy     = (state_q != S_IDLE);
        accept   = X_tvalid && Y_tvalid && X_tready;
        mul_a    = mul_a_q;
        mul_b    = mul_b_q;
        Z_tdata  = z_q;
    end

    // Datapath: operand split, issue mux, capture, recombination
    always_comb begin
        dx      = {1'b0, X_tdata[m2-1:0]} - {1'b0, X_tdata[m-1:m2]};
        dy      = {1'b0, Y_tdata[m-1:m2]} - {1'b0, Y_tdata[m2-1:0]};
        x1_d    = x1_q;
        y1_d    = y1_q;
        dxm_d   = dxm_q;
        dym_d   = dym_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        if (accept) begin
            x1_d    = X_tdata[m-1:m2];
            y1_d    = Y_tdata[m-1:m2];
            sx_d    = dx[m2];
            sy_d    = dy[m2];
            dxm_d   = dx[m2] ? -dx[m2-1:0] : dx[m2-1:0];
            dym_d   = dy[m2] ? -dy[m2-1:0] : dy[m2-1:0];
            // Slot 0 goes out on the accept edge itself
            mul_a_d = X_tdata[m2-1:0];
            mul_b_d = Y_tdata[m2-1:0];
            cnt_d   = '0;
        end
        if (state_q == S_ISSUE) begin
            if (cnt_q == CW'(0)) begin
                mul_a_d = x1_q;
                mul_b_d = y1_q;
            end else if (cnt_q == CW'(1)) begin
                mul_a_d = dxm_q;
                mul_b_d = dym_q;
            end
        end
        cap_en = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        if (cap_en) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Slot k product is on mul_p while cnt == LAT+k
        z0_d = (cap_en && cnt_q == CW'(LAT))     ? mul_p : z0_q;
        z2_d = (cap_en && cnt_q == CW'(LAT + 1)) ? mul_p : z2_q;
        xy_d = (cap_en && cnt_q == CW'(LAT + 2)) ? mul_p : xy_q;
        // True cross term is non-negative, so m+1 bit wraparound is exact
        if (sx_q == sy_q) begin
            z1 = {1'b0, z2_q} + {1'b0, z0_q} + {1'b0, xy_q};
        end else begin
            z1 = {1'b0, z2_q} + {1'b0, z0_q} - {1'b0, xy_q};
        end
        if (state_q == S_COMBINE) begin
            z_d = {z2_q, z0_q} + ({{(m - 1){1'b0}}, z1} << m2);
        end
    end
endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Bench for karatsuba_seq_ctrl: directed m=8/LAT=2 cases plus randomized
// m=328 streams at LAT 1, 2 and 4 checked against a plain X*Y scoreboard.
module tb_karatsuba_seq_ctrl;
    localparam int W  = 328;
    localparam int H  = 164;
    localparam int NV = 1200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdone = 0;
    logic rrst;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v;
        int s;
        v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) v = {v[W-33:0], 32'($urandom)};
        s = $urandom_range(0, 9);
        if (s == 0) v = '1;
        else if (s == 1) v = '0;
        else if (s == 2) v = {v[H-1:0], v[H-1:0]};
        return v;
    endfunction

    // ---------------- directed DUT: m=8, LAT=2 ----------------
    logic        drst, dxv, dyv, dxr, dyr, dzv, dzr, dbusy;
    logic [7:0]  dxd, dyd, dmp;
    logic [15:0] dzd;
    logic [3:0]  dma, dmb;
    logic [7:0]  dpipe [2];
    logic [15:0] dq[$];
    int          dacc[$];

    always @(posedge clk) begin
        dpipe[0] <= {4'h0, dma} * {4'h0, dmb};
        dpipe[1] <= dpipe[0];
    end
    assign dmp = dpipe[1];

    karatsuba_seq_ctrl #(.m(8), .LAT(2)) u_dir (
        .clk(clk), .rst(drst),
        .X_tvalid(dxv), .X_tready(dxr), .X_tdata(dxd),
        .Y_tvalid(dyv), .Y_tready(dyr), .Y_tdata(dyd),
        .Z_tvalid(dzv), .Z_tready(dzr), .Z_tdata(dzd),
        .mul_a(dma), .mul_b(dmb), .mul_p(dmp), .busy(dbusy)
    );

    initial begin
        logic pv;
        int a;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (dzv && !pv && dacc.size() > 0) begin
                a = dacc.pop_front();
                chk("dir_latency", 2*W'(cyc - a), 2*W'(6));
            end
            if (dzv && dzr) begin
                if (dq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dir_unexpected_output actual=%0h required=none", dzd);
                end else begin
                    chk("dir_data", dzd, dq.pop_front());
                end
            end
            pv = dzv;
        end
    end

    task automatic dsend(input logic [7:0] x, input logic [7:0] y);
        int t;
        t = 0;
        dxd = x;
        dyd = y;
        dxv = 1'b1;
        dyv = 1'b1;
        @(negedge clk);
        while (!dxr && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!dxr) begin
            checks++;
            failures++;
            $display("FAIL dir_accept_timeout actual=not_ready required=ready");
        end else begin
            dq.push_back({8'h00, x} * {8'h00, y});
            dacc.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        dxv = 1'b0;
        dyv = 1'b0;
    endtask

    task automatic dwait();
        int t;
        t = 0;
        while (dq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (dq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL dir_output_timeout pending=%0d required=0", dq.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- random DUTs: m=328, LAT 1/2/4 ----------------
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int LT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic           xv, yv, xr, yr, zv, zr, bsy;
        logic [W-1:0]   xd, yd, mp;
        logic [2*W-1:0] zd;
        logic [H-1:0]   ma, mb;
        logic [W-1:0]   pipe [LT];
        logic [2*W-1:0] q[$];

        always @(posedge clk) begin
            pipe[0] <= {{H{1'b0}}, ma} * {{H{1'b0}}, mb};
            for (int i = 1; i < LT; i++) pipe[i] <= pipe[i-1];
        end
        assign mp = pipe[LT-1];

        karatsuba_seq_ctrl #(.m(W), .LAT(LT)) u_rnd (
            .clk(clk), .rst(rrst),
            .X_tvalid(xv), .X_tready(xr), .X_tdata(xd),
            .Y_tvalid(yv), .Y_tready(yr), .Y_tdata(yd),
            .Z_tvalid(zv), .Z_tready(zr), .Z_tdata(zd),
            .mul_a(ma), .mul_b(mb), .mul_p(mp), .busy(bsy)
        );

        initial begin
            zr = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                zr = ($urandom_range(0, 3) != 0);
            end
        end

        initial begin
            int n;
            int r;
            int t;
            logic acc;
            n = 0;
            acc = 1'b0;
            xv = 1'b0;
            yv = 1'b0;
            xd = rnd_w();
            yd = rnd_w();
            @(posedge clk);
            while (rrst) @(posedge clk);
            while (n < NV) begin
                @(posedge clk);
                #1;
                if (acc) begin
                    xd = rnd_w();
                    yd = rnd_w();
                end
                r = $urandom_range(0, 7);
                xv = (r != 0) && (r != 2);
                yv = (r != 0) && (r != 1);
                @(negedge clk);
                acc = xv && yv && xr && yr;
                if (acc) begin
                    q.push_back({{W{1'b0}}, xd} * {{W{1'b0}}, yd});
                    n++;
                end
            end
            @(posedge clk);
            #1;
            xv = 1'b0;
            yv = 1'b0;
            t = 0;
            while (q.size() != 0 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (q.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL rnd_drain_timeout lat=%0d pending=%0d required=0", LT, q.size());
            end
            rdone++;
        end

        initial begin
            forever begin
                @(negedge clk);
                if (zv) chk($sformatf("rnd_busy_lat%0d", LT), 2*W'(bsy), 2*W'(1));
                if (zv && zr) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rnd_unexpected_output lat=%0d actual=%0h required=none", LT, zd);
                    end else begin
                        chk($sformatf("rnd_data_lat%0d", LT), zd, q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        logic [15:0] held;
        drst = 1'b1;
        rrst = 1'b1;
        dxv = 1'b0;
        dyv = 1'b0;
        dxd = 8'h00;
        dyd = 8'h00;
        dzr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x_ready", dxr, 1'b0);
        chk("rst_y_ready", dyr, 1'b0);
        chk("rst_z_valid", dzv, 1'b0);
        chk("rst_z_data", dzd, 16'h0000);
        chk("rst_mul_a", dma, 4'h0);
        chk("rst_mul_b", dmb, 4'h0);
        chk("rst_busy", dbusy, 1'b0);
        @(posedge clk);
        #1;
        drst = 1'b0;
        rrst = 1'b0;
        dzr = 1'b1;
        @(negedge clk);
        chk("idle_x_ready", dxr, 1'b1);
        chk("idle_y_ready", dyr, 1'b1);
        chk("idle_busy", dbusy, 1'b0);
        @(posedge clk);
        #1;

        dsend(8'h12, 8'h34);
        dwait();
        dsend(8'hFF, 8'hFF);
        dwait();
        dsend(8'h00, 8'hAB);
        dwait();
        dsend(8'h21, 8'h12);
        dwait();
        dsend(8'h21, 8'h21);
        dwait();

        // Lone X valid must not start an operation
        dxd = 8'h77;
        dxv = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("lone_busy", dbusy, 1'b0);
            chk("lone_ready", dxr, 1'b1);
        end
        @(posedge clk);
        #1;
        dxv = 1'b0;

        // Output backpressure
        dzr = 1'b0;
        dsend(8'h9C, 8'h5B);
        t = 0;
        while (!dzv && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid", dzv, 1'b1);
        held = dzd;
        repeat (10) begin
            @(negedge clk);
            chk("bp_data_stable", dzd, held);
            chk("bp_x_ready_low", dxr, 1'b0);
            chk("bp_valid_held", dzv, 1'b1);
        end
        @(posedge clk);
        #1;
        dzr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_after_release", dxr, 1'b1);
        chk("bp_valid_after_release", dzv, 1'b0);
        @(posedge clk);
        #1;

        // Reset during DRAIN drops the operation
        dsend(8'h55, 8'h66);
        repeat (3) @(posedge clk);
        #1;
        drst = 1'b1;
        dq.delete();
        dacc.delete();
        @(posedge clk);
        #1;
        drst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", dzv, 1'b0);
        chk("rst_mid_busy", dbusy, 1'b0);
        chk("rst_mid_ready", dxr, 1'b1);
        @(posedge clk);
        #1;
        dsend(8'h12, 8'h34);
        dwait();
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_stale", dzv, 1'b0);
        end

        wait (rdone == 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout required=completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
